// File: rtl/encoder_16to4_seq.sv
// Sequential priority encoder: captures a multi-hot request vector and emits the
// binary index of each set bit, one per output handshake, in priority order.
module encoder_16to4_seq #(
   parameter int N_IN      = 16,
   parameter int SEL_W     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] out,
   output logic             out_zero,
   output logic             out_last,
   output logic             busy
);

   // state | meaning
   // IDLE  | no vector held, ready to capture
   // EMIT  | pending vector held, one beat presented per cycle while enabled
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]      state, state_nxt;
   logic [N_IN-1:0] pend, pend_nxt;
   logic            zero_nxt;
   logic            accept;
   logic            capture;

   function automatic logic [SEL_W-1:0] prio_idx(input logic [N_IN-1:0] v);
      logic [SEL_W-1:0] r;
      r = '0;
      if (LSB_FIRST) begin
         for (int i = N_IN - 1; i >= 0; i--)
            if (v[i]) r = SEL_W'(i);
      end else begin
         for (int i = 0; i < N_IN; i++)
            if (v[i]) r = SEL_W'(i);
      end
      return r;
   endfunction

   function automatic logic single_bit(input logic [N_IN-1:0] v);
      return (v != '0) && ((v & (v - N_IN'(1))) == '0);
   endfunction

   assign out_valid = enable & (state == ST_EMIT);
   assign busy      = (state == ST_EMIT);
   assign accept    = out_valid & out_ready;
   assign in_ready  = enable & ((state == ST_IDLE) | (accept & out_last));
   assign capture   = in_valid & in_ready;

   // A capture on the last-beat edge takes precedence so vectors stream with no bubble.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      zero_nxt  = out_zero;
      if (capture) begin
         state_nxt = ST_EMIT;
         pend_nxt  = in;
         zero_nxt  = (in == '0);
      end else if (accept) begin
         pend_nxt = pend & ~(N_IN'(1) << out);
         if (out_last) begin
            state_nxt = ST_IDLE;
            pend_nxt  = '0;
            zero_nxt  = 1'b0;
         end
      end
   end

   // Beat outputs are registered from the next pending vector, so they only move
   // on capture or accept and stay stable while the consumer back-pressures.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pend     <= '0;
         out      <= '0;
         out_zero <= 1'b0;
         out_last <= 1'b0;
      end else if (enable) begin
         state    <= state_nxt;
         pend     <= pend_nxt;
         out_zero <= zero_nxt;
         if (state_nxt == ST_EMIT) begin
            out      <= prio_idx(pend_nxt);
            out_last <= zero_nxt | single_bit(pend_nxt);
         end else begin
            out      <= '0;
            out_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// Directed bench for encoder_16to4_seq: LSB-first instance for most scenarios,
// an MSB-first instance for the descending-order and decode round-trip check.
module tb_encoder_16to4_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable, in_valid, out_ready;
   logic [15:0] in;
   logic        in_ready, out_valid, out_zero, out_last, busy;
   logic [3:0]  out;

   logic        enable_b, in_valid_b, out_ready_b;
   logic [15:0] in_b;
   logic        in_ready_b, out_valid_b, out_zero_b, out_last_b, busy_b;
   logic [3:0]  out_b;

   int total = 0;
   int bad   = 0;
   logic [15:0] acc;
   logic [15:0] one16;

   always #5 clk = ~clk;

   encoder_16to4_seq #(.N_IN(16), .SEL_W(4), .LSB_FIRST(1'b1)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in(in), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_zero(out_zero), .out_last(out_last), .busy(busy)
   );

   encoder_16to4_seq #(.N_IN(16), .SEL_W(4), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .enable(enable_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in(in_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out(out_b),
      .out_zero(out_zero_b), .out_last(out_last_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in = '0;
      enable_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b0; in_b = '0;
      one16 = 16'h0001;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_out",       32'(out),       32'd0);
      chk("rst_out_zero",  32'(out_zero),  32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // 8421 streamed with out_ready held high
      in = 16'h8421; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("v8421_c0", 32'(out), 32'd0);  chk("v8421_l0", 32'(out_last), 32'd0);
      chk("v8421_valid", 32'(out_valid), 32'd1);
      tick();
      chk("v8421_c1", 32'(out), 32'd5);  chk("v8421_l1", 32'(out_last), 32'd0);
      tick();
      chk("v8421_c2", 32'(out), 32'd10); chk("v8421_l2", 32'(out_last), 32'd0);
      tick();
      chk("v8421_c3", 32'(out), 32'd15); chk("v8421_l3", 32'(out_last), 32'd1);
      chk("v8421_v3", 32'(out_valid), 32'd1);
      tick();
      chk("v8421_idle_valid", 32'(out_valid), 32'd0);
      chk("v8421_idle_busy",  32'(busy),      32'd0);

      // zero vector: one beat flagged out_zero
      in = 16'h0000; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("zero_valid", 32'(out_valid), 32'd1);
      chk("zero_out",   32'(out),       32'd0);
      chk("zero_flag",  32'(out_zero),  32'd1);
      chk("zero_last",  32'(out_last),  32'd1);
      chk("zero_busy",  32'(busy),      32'd1);
      out_ready = 1'b1;
      tick();
      chk("zero_done_valid", 32'(out_valid), 32'd0);
      chk("zero_done_flag",  32'(out_zero),  32'd0);

      // 0006 with back-pressure, then 0001 captured on the last-beat edge
      in = 16'h0006; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_hold_out",    32'(out),       32'd1);
         chk("bp_hold_valid",  32'(out_valid), 32'd1);
         chk("bp_hold_last",   32'(out_last),  32'd0);
         chk("bp_hold_ready",  32'(in_ready),  32'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_first", 32'(out), 32'd1);
      tick();
      chk("bp_second", 32'(out), 32'd2);
      chk("bp_second_last", 32'(out_last), 32'd1);
      in = 16'h0001; in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_out",   32'(out),       32'd0);
      chk("b2b_last",  32'(out_last),  32'd1);
      chk("b2b_zero",  32'(out_zero),  32'd0);
      tick();
      chk("b2b_idle", 32'(out_valid), 32'd0);

      // reset in the middle of 00F0
      in = 16'h00F0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rstmid_c4", 32'(out), 32'd4);
      tick();
      chk("rstmid_c5", 32'(out), 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rstmid_valid",    32'(out_valid), 32'd0);
      chk("rstmid_busy",     32'(busy),      32'd0);
      chk("rstmid_in_ready", 32'(in_ready),  32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rstmid_no_leftover", 32'(out_valid), 32'd0);
      end

      // FFFF with a 2-cycle enable stall after the 4th beat
      in = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("ones_pre", 32'(out), 32'(k));
         tick();
      end
      enable = 1'b0;
      #1;
      chk("stall_valid",    32'(out_valid), 32'd0);
      chk("stall_in_ready", 32'(in_ready),  32'd0);
      tick();
      chk("stall_valid2", 32'(out_valid), 32'd0);
      chk("stall_out",    32'(out),       32'd4);
      tick();
      enable = 1'b1;
      #1;
      chk("resume_valid", 32'(out_valid), 32'd1);
      for (int k = 4; k < 16; k++) begin
         chk("ones_post", 32'(out), 32'(k));
         chk("ones_last", 32'(out_last), (k == 15) ? 32'd1 : 32'd0);
         tick();
      end
      chk("ones_done", 32'(out_valid), 32'd0);

      // MSB-first instance, 0300, decode round-trip
      acc = '0;
      in_b = 16'h0300; in_valid_b = 1'b1; out_ready_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      chk("msb_c9",   32'(out_b),      32'd9);
      chk("msb_l9",   32'(out_last_b), 32'd0);
      acc = acc | (one16 << out_b);
      tick();
      chk("msb_c8",   32'(out_b),      32'd8);
      chk("msb_l8",   32'(out_last_b), 32'd1);
      acc = acc | (one16 << out_b);
      tick();
      chk("msb_roundtrip", 32'(acc), 32'h0300);
      chk("msb_idle", 32'(out_valid_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
